stream_demux_1to4: RTL and testbench

STREAM_DEMUX_1TO4 -- requirements
Module: stream_demux_1to4

---
 rtl/stream_demux_1to4.sv | 93 +++++++++
 tb/tb_stream_demux_1to4.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1to4.sv
// Stream demultiplexer: one valid/ready source fanned out to four single-entry output buffers.
// Optional macro DEMUX_CNT_EN adds four 16-bit per-channel delivery counters on xfer_cnt.
module stream_demux_1to4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [63:0]      xfer_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e      state_q [4];
  chan_state_e      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic             accept;
  logic [3:0]       deliver;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  // A full channel can still accept when its sink drains in the same cycle.
  always_comb begin
    in_ready  = 1'b0;
    accept    = 1'b0;
    deliver   = '0;
    out_valid = '0;
    in_ready  = ~rst & ((state_q[in_sel] == EMPTY) | out_ready[in_sel]);
    accept    = in_valid & in_ready;
    for (int k = 0; k < 4; k++) begin
      state_d[k]   = state_q[k];
      data_d[k]    = data_q[k];
      out_valid[k] = (state_q[k] == FULL);
      deliver[k]   = (state_q[k] == FULL) & out_ready[k];
      if (accept && (in_sel == 2'(k))) begin
        state_d[k] = FULL;
        data_d[k]  = in_data;
      end else if (deliver[k]) begin
        state_d[k] = EMPTY;
      end
    end
  end

  assign out1 = data_q[0];
  assign out2 = data_q[1];
  assign out3 = data_q[2];
  assign out4 = data_q[3];

`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (deliver[k]) cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  assign xfer_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Testbench for stream_demux_1to4: directed scenarios plus a randomized stream
// checked every cycle against a queue-based model of the four channels.
module tb_stream_demux_1to4;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] inData = '0;
  logic [1:0]       inSel = '0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [WIDTH-1:0] out1, out2, out3, out4;
  logic [3:0]       outValid;
  logic [3:0]       outReady = '0;
`ifdef DEMUX_CNT_EN
  logic [63:0]      xferCnt;
`endif

  int nVectors = 0;
  int nMiscompares = 0;

  // Model: words waiting per channel, last word loaded per channel, deliveries per channel.
  logic [WIDTH-1:0] held [4][$];
  logic [WIDTH-1:0] lastLoaded [4];
  int unsigned      deliveries [4];

  logic             acc;
  logic             pending;
  logic             rv;
  logic [1:0]       rs;
  logic [WIDTH-1:0] rd;
  logic [3:0]       rr;

  always #5 clk = ~clk;

  stream_demux_1to4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData),
    .in_sel    (inSel),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out_valid (outValid),
    .out_ready (outReady)
`ifdef DEMUX_CNT_EN
    ,
    .xfer_cnt  (xferCnt)
`endif
  );

  function automatic logic [WIDTH-1:0] dutOut(input int k);
    case (k)
      0:       return out1;
      1:       return out2;
      2:       return out3;
      default: return out4;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 4; k++) begin
      held[k].delete();
      lastLoaded[k] = '0;
      deliveries[k] = 0;
    end
  endtask

  // Compare every DUT output against what the model says it must be right now.
  task automatic checkOutput();
    logic [3:0] expValid;
    logic       expReady;
    for (int k = 0; k < 4; k++) expValid[k] = (held[k].size() != 0);
    expReady = !rst && ((held[inSel].size() == 0) || outReady[inSel]);
    check("in_ready", 64'(inReady), 64'(expReady));
    check("out_valid", 64'(outValid), 64'(expValid));
    for (int k = 0; k < 4; k++)
      check($sformatf("out%0d", k + 1), 64'(dutOut(k)), 64'(lastLoaded[k]));
`ifdef DEMUX_CNT_EN
    for (int k = 0; k < 4; k++)
      check($sformatf("xfer_cnt%0d", k + 1), 64'(xferCnt[16*k +: 16]), 64'(16'(deliveries[k])));
`endif
  endtask

  // Drive one cycle of inputs (called at a falling edge), check, then advance the model.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                               input logic [3:0] r, output logic accepted);
    logic [3:0] deliver;
    logic       expReady;
    inValid  = v;
    inSel    = s;
    inData   = d;
    outReady = r;
    #1 checkOutput();
    expReady = (held[s].size() == 0) || r[s];
    accepted = v && expReady;
    for (int k = 0; k < 4; k++) deliver[k] = (held[k].size() != 0) && r[k];
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (deliver[k]) begin
        void'(held[k].pop_front());
        deliveries[k]++;
      end
    end
    if (accepted) begin
      held[s].push_back(d);
      lastLoaded[s] = d;
    end
    @(negedge clk);
  endtask

  initial begin
    modelReset();
    #1 rst = 1'b1;
    @(negedge clk);
    #1 checkOutput();
    check("reset in_ready", 64'(inReady), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single word into channel 3.
    applyStimulus(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, acc);
    inValid = 1'b0;
    #1;
    check("lit out3", 64'(out3), 64'hDEADBEEF);
    check("lit out_valid single", 64'(outValid), 64'h4);
    check("lit out1 idle", 64'(out1), 64'h0);
    check("lit out2 idle", 64'(out2), 64'h0);
    check("lit out4 idle", 64'(out4), 64'h0);
    @(negedge clk);

    // Backpressure on full channel 1, then drain-and-refill in one cycle.
    applyStimulus(1'b1, 2'd0, 32'h11, 4'b0000, acc);
    inValid = 1'b1; inSel = 2'd0; inData = 32'h22; outReady = 4'b0000;
    #1;
    check("lit blocked in_ready", 64'(inReady), 64'h0);
    check("lit blocked out1", 64'(out1), 64'h11);
    applyStimulus(1'b1, 2'd0, 32'h22, 4'b0000, acc);
    outReady = 4'b0001;
    #1;
    check("lit drain in_ready", 64'(inReady), 64'h1);
    applyStimulus(1'b1, 2'd0, 32'h22, 4'b0001, acc);
    check("lit replaced out1", 64'(out1), 64'h22);
    check("lit replaced valid1", 64'(outValid[0]), 64'h1);

    // Back-to-back stream into channel 4 with its sink always ready.
    for (int i = 1; i <= 4; i++) begin
      inValid = 1'b1; inSel = 2'd3; inData = 32'(i); outReady = 4'b1000;
      #1;
      check("lit stream in_ready", 64'(inReady), 64'h1);
      applyStimulus(1'b1, 2'd3, 32'(i), 4'b1000, acc);
      check("lit stream out4", 64'(out4), 64'(i));
      check("lit stream valid4", 64'(outValid[3]), 64'h1);
    end

    // Fill channel 2 so all four are full, then drain everything at once.
    applyStimulus(1'b1, 2'd1, 32'h55, 4'b0000, acc);
    check("lit all full", 64'(outValid), 64'hF);
    applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, acc);
    check("lit all drained", 64'(outValid), 64'h0);

    // Asynchronous reset with channels 2 and 3 holding words.
    applyStimulus(1'b1, 2'd1, 32'hA, 4'b0000, acc);
    applyStimulus(1'b1, 2'd2, 32'hB, 4'b0000, acc);
    inValid = 1'b0; outReady = 4'b0000;
    #2 rst = 1'b1;
    #1;
    check("lit async out_valid", 64'(outValid), 64'h0);
    check("lit async out2", 64'(out2), 64'h0);
    check("lit async out3", 64'(out3), 64'h0);
    check("lit async in_ready", 64'(inReady), 64'h0);
    modelReset();
    @(negedge clk);
    #1 checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 2'd0, 32'h77, 4'b0000, acc);
    check("lit first accept out1", 64'(out1), 64'h77);
    check("lit first accept valid", 64'(outValid), 64'h1);

`ifdef DEMUX_CNT_EN
    // Run channel 1's delivery counter up to 0xFFFF, then one more delivery wraps it.
    for (int c = 0; c < 70000 && (deliveries[0] & 32'hFFFF) != 32'hFFFF; c++)
      applyStimulus(1'b1, 2'd0, 32'(c), 4'b0001, acc);
    check("cnt preload", 64'(xferCnt[15:0]), 64'hFFFF);
    begin
      logic [47:0] upperExp;
      upperExp = {16'(deliveries[3]), 16'(deliveries[2]), 16'(deliveries[1])};
      applyStimulus(1'b0, 2'd0, 32'h0, 4'b0001, acc);
      check("lit cnt wrap", 64'(xferCnt[15:0]), 64'h0);
      check("cnt others", 64'(xferCnt[63:16]), 64'(upperExp));
    end
`endif

    // Randomized traffic; a refused offer is held until it is taken.
    pending = 1'b0;
    rv = 1'b0; rs = '0; rd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!pending) begin
        rv = ($urandom_range(0, 9) < 7);
        rs = 2'($urandom_range(0, 3));
        rd = $urandom;
      end
      rr = 4'($urandom);
      applyStimulus(rv, rs, rd, rr, acc);
      pending = rv && !acc;
    end

    // Drain whatever is left and confirm every channel empties.
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, acc);
    #1 checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
